reg_file_lq: RTL and testbench

//  Parametrised successor of the byter register module. Provides a multi-read register file with
//  ALU/literal write-back plus a non-blocking memory-load queue. Loads are issued with a destination

---
 rtl/reg_file_lq.sv | 154 +++++++++++++++
 tb/tb_reg_file_lq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_lq.sv
// Multi-read register file with ALU/literal write-back and an in-order non-blocking load queue.
// A per-register scoreboard stalls requests that touch a register still waiting on load data.
module reg_file_lq #(
  parameter int WIDTH    = 8,
  parameter int NREGS    = 16,
  parameter int LQ_DEPTH = 4,
  parameter int PC_W     = 13,
  parameter int PCL_REG  = 14,
  parameter int PCH_REG  = 15,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(LQ_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             regEn,
  input  logic             litEn,
  input  logic             ldReq,
  input  logic [AW-1:0]    SA,
  input  logic [AW-1:0]    SB,
  input  logic [AW-1:0]    SD,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] lit,
  input  logic             memValid,
  input  logic [WIDTH-1:0] memData,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [PC_W-1:0]  pcAddData,
  output logic             stall,
  output logic             ldFull,
  output logic [CW-1:0]    pendCount,
  output logic             memErr
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

  logic [WIDTH-1:0]    regs  [NREGS];
  logic [AW-1:0]       q_dst [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] q_vld;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic                mem_err;

  logic                q_empty;
  logic                ret;
  logic [AW-1:0]       head_dst;
  logic [NREGS-1:0]    pend_eff;
  logic                haz_a;
  logic                haz_b;
  logic                haz_d;
  logic                wr_en;
  logic                push;
  logic [WIDTH-1:0]    wr_val;

  function automatic logic in_range(input logic [AW-1:0] idx);
    return {1'b0, idx} < (AW+1)'(NREGS);
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(LQ_DEPTH - 1))
      return '0;
    else
      return p + PW'(1);
  endfunction

  assign q_empty  = (count == '0);
  assign ret      = memValid & ~q_empty;
  assign head_dst = q_dst[head];
  assign ldFull   = (count == CW'(LQ_DEPTH));

  // The head entry stops counting as a hazard in the cycle its data returns.
  always_comb begin
    pend_eff = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (q_vld[i] && !(ret && (PW'(i) == head)) && in_range(q_dst[i]))
        pend_eff[q_dst[i]] = 1'b1;
    end
  end

  assign haz_a  = in_range(SA) & pend_eff[SA];
  assign haz_b  = in_range(SB) & pend_eff[SB];
  assign haz_d  = in_range(SD) & pend_eff[SD];

  assign stall  = ((regEn | ldReq) & (haz_a | haz_b | haz_d))
                | (ldReq & ldFull & ~memValid);

  assign wr_val = litEn ? lit : data;
  assign wr_en  = regEn & ~ldReq & ~stall & in_range(SD);
  assign push   = ldReq & ~stall & in_range(SD);

  always_comb begin
    A = '0;
    if (in_range(SA)) begin
      if (ret && (head_dst == SA))
        A = memData;
      else if (wr_en && (SD == SA))
        A = wr_val;
      else
        A = regs[SA];
    end
  end

  always_comb begin
    B = '0;
    if (in_range(SB)) begin
      if (ret && (head_dst == SB))
        B = memData;
      else if (wr_en && (SD == SB))
        B = wr_val;
      else
        B = regs[SB];
    end
  end

  assign pcAddData = {regs[PCH_REG][PC_W-WIDTH-1:0], regs[PCL_REG]};
  assign pendCount = count;
  assign memErr    = mem_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
      for (int i = 0; i < LQ_DEPTH; i++)
        q_dst[i] <= '0;
      q_vld   <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      mem_err <= 1'b0;
    end else begin
      if (wr_en)
        regs[SD] <= wr_val;
      if (ret) begin
        regs[head_dst] <= memData;
        q_vld[head]    <= 1'b0;
        head           <= ptr_next(head);
      end
      if (memValid && q_empty)
        mem_err <= 1'b1;
      // Push after pop so a simultaneous push into the slot just freed at full keeps its valid bit.
      if (push) begin
        q_dst[tail] <= SD;
        q_vld[tail] <= 1'b1;
        tail        <= ptr_next(tail);
      end
      case ({push, ret})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_lq.sv
// Directed bench for reg_file_lq: a table of per-cycle vectors with hand-computed outputs,
// plus hand-written reset sequences.
module tb_reg_file_lq;

  logic        clk = 1'b0;
  logic        reset;
  logic        regEn, litEn, ldReq, memValid;
  logic [3:0]  SA, SB, SD;
  logic [7:0]  data, lit, memData;
  logic [7:0]  A, B;
  logic [12:0] pcAddData;
  logic        stall, ldFull, memErr;
  logic [2:0]  pendCount;

  int n_chk  = 0;
  int n_fail = 0;

  reg_file_lq dut (
    .clk(clk), .reset(reset), .regEn(regEn), .litEn(litEn), .ldReq(ldReq),
    .SA(SA), .SB(SB), .SD(SD), .data(data), .lit(lit),
    .memValid(memValid), .memData(memData),
    .A(A), .B(B), .pcAddData(pcAddData), .stall(stall), .ldFull(ldFull),
    .pendCount(pendCount), .memErr(memErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re, le, lq;
    logic [3:0]  sa, sb, sd;
    logic [7:0]  d, l;
    logic        mv;
    logic [7:0]  md;
    logic [7:0]  ea, eb;
    logic        est;
    logic [2:0]  ep;
    logic        ef;
    logic [12:0] epc;
    logic        eerr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic re, le, lq, input logic [3:0] sa, sb, sd,
    input logic [7:0] d, l, input logic mv, input logic [7:0] md,
    input logic [7:0] ea, eb, input logic est, input logic [2:0] ep,
    input logic ef, input logic [12:0] epc, input logic eerr);
    vec_t v;
    v.re = re; v.le = le; v.lq = lq; v.sa = sa; v.sb = sb; v.sd = sd;
    v.d = d; v.l = l; v.mv = mv; v.md = md;
    v.ea = ea; v.eb = eb; v.est = est; v.ep = ep; v.ef = ef; v.epc = epc; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle();
    regEn = 0; litEn = 0; ldReq = 0; memValid = 0;
    SA = 0; SB = 0; SD = 0; data = 0; lit = 0; memData = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #12;
    chk("rst A", A, 8'h00);
    chk("rst B", B, 8'h00);
    chk("rst pc", pcAddData, 13'h0000);
    chk("rst stall", stall, 1'b0);
    chk("rst pend", pendCount, 3'd0);
    chk("rst memErr", memErr, 1'b0);
    chk("rst ldFull", ldFull, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step();

    //            re le lq sa    sb    sd    d      l      mv md      A      B      st p  f  pc         err
    vq.push_back(mk(1,0,0, 4'h0, 4'h1, 4'h0, 8'h11, 8'h00, 0, 8'h00, 8'h11, 8'h00, 0, 0, 0, 13'h0000, 0));
    vq.push_back(mk(0,0,0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 8'h00, 8'h11, 8'h11, 0, 0, 0, 13'h0000, 0));
    vq.push_back(mk(1,1,0, 4'hE, 4'h0, 4'hE, 8'h99, 8'h44, 0, 8'h00, 8'h44, 8'h11, 0, 0, 0, 13'h0000, 0));
    vq.push_back(mk(1,0,0, 4'hF, 4'hE, 4'hF, 8'h05, 8'h00, 0, 8'h00, 8'h05, 8'h44, 0, 0, 0, 13'h0044, 0));
    vq.push_back(mk(0,0,0, 4'hE, 4'hF, 4'h0, 8'h00, 8'h00, 0, 8'h00, 8'h44, 8'h05, 0, 0, 0, 13'h0544, 0));
    vq.push_back(mk(0,0,1, 4'h0, 4'h0, 4'h3, 8'h00, 8'h00, 0, 8'h00, 8'h11, 8'h11, 0, 0, 0, 13'h0544, 0));
    vq.push_back(mk(1,0,0, 4'h3, 4'h0, 4'h5, 8'h77, 8'h00, 0, 8'h00, 8'h00, 8'h11, 1, 1, 0, 13'h0544, 0));
    vq.push_back(mk(1,0,0, 4'h3, 4'h0, 4'h5, 8'h77, 8'h00, 1, 8'h88, 8'h88, 8'h11, 0, 1, 0, 13'h0544, 0));
    vq.push_back(mk(0,0,0, 4'h3, 4'h5, 4'h0, 8'h00, 8'h00, 0, 8'h00, 8'h88, 8'h77, 0, 0, 0, 13'h0544, 0));
    vq.push_back(mk(0,0,1, 4'h0, 4'h0, 4'h1, 8'h00, 8'h00, 0, 8'h00, 8'h11, 8'h11, 0, 0, 0, 13'h0544, 0));
    vq.push_back(mk(0,0,1, 4'h0, 4'h0, 4'h2, 8'h00, 8'h00, 0, 8'h00, 8'h11, 8'h11, 0, 1, 0, 13'h0544, 0));
    vq.push_back(mk(0,0,1, 4'h0, 4'h0, 4'h3, 8'h00, 8'h00, 0, 8'h00, 8'h11, 8'h11, 0, 2, 0, 13'h0544, 0));
    vq.push_back(mk(0,0,1, 4'h0, 4'h0, 4'h4, 8'h00, 8'h00, 0, 8'h00, 8'h11, 8'h11, 0, 3, 0, 13'h0544, 0));
    vq.push_back(mk(0,0,1, 4'h0, 4'h0, 4'h6, 8'h00, 8'h00, 0, 8'h00, 8'h11, 8'h11, 1, 4, 1, 13'h0544, 0));
    vq.push_back(mk(0,0,1, 4'h0, 4'h0, 4'h6, 8'h00, 8'h00, 1, 8'h0A, 8'h11, 8'h11, 0, 4, 1, 13'h0544, 0));
    vq.push_back(mk(0,0,0, 4'h1, 4'h2, 4'h0, 8'h00, 8'h00, 0, 8'h00, 8'h0A, 8'h00, 0, 4, 1, 13'h0544, 0));
    vq.push_back(mk(0,0,0, 4'h2, 4'h1, 4'h0, 8'h00, 8'h00, 1, 8'h0B, 8'h0B, 8'h0A, 0, 4, 1, 13'h0544, 0));
    vq.push_back(mk(0,0,0, 4'h3, 4'h4, 4'h0, 8'h00, 8'h00, 1, 8'h0C, 8'h0C, 8'h00, 0, 3, 0, 13'h0544, 0));
    vq.push_back(mk(0,0,0, 4'h4, 4'h3, 4'h0, 8'h00, 8'h00, 1, 8'h0D, 8'h0D, 8'h0C, 0, 2, 0, 13'h0544, 0));
    vq.push_back(mk(0,0,0, 4'h6, 4'h0, 4'h0, 8'h00, 8'h00, 1, 8'h5A, 8'h5A, 8'h11, 0, 1, 0, 13'h0544, 0));
    vq.push_back(mk(0,0,0, 4'h1, 4'h4, 4'h0, 8'h00, 8'h00, 0, 8'h00, 8'h0A, 8'h0D, 0, 0, 0, 13'h0544, 0));
    vq.push_back(mk(0,0,0, 4'h0, 4'h6, 4'h0, 8'h00, 8'h00, 1, 8'hFF, 8'h11, 8'h5A, 0, 0, 0, 13'h0544, 0));
    vq.push_back(mk(0,0,0, 4'h0, 4'h6, 4'h0, 8'h00, 8'h00, 0, 8'h00, 8'h11, 8'h5A, 0, 0, 0, 13'h0544, 1));
    vq.push_back(mk(0,0,1, 4'h0, 4'h0, 4'h7, 8'h00, 8'h00, 0, 8'h00, 8'h11, 8'h11, 0, 0, 0, 13'h0544, 1));
    vq.push_back(mk(1,0,0, 4'h0, 4'h0, 4'h7, 8'h22, 8'h00, 0, 8'h00, 8'h11, 8'h11, 1, 1, 0, 13'h0544, 1));
    vq.push_back(mk(1,0,0, 4'h0, 4'h7, 4'h8, 8'h22, 8'h00, 0, 8'h00, 8'h11, 8'h00, 1, 1, 0, 13'h0544, 1));
    vq.push_back(mk(0,0,1, 4'h7, 4'h0, 4'h8, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h11, 1, 1, 0, 13'h0544, 1));
    vq.push_back(mk(1,0,0, 4'h7, 4'h8, 4'h8, 8'h22, 8'h00, 1, 8'hC3, 8'hC3, 8'h22, 0, 1, 0, 13'h0544, 1));
    vq.push_back(mk(0,0,0, 4'h7, 4'h8, 4'h0, 8'h00, 8'h00, 0, 8'h00, 8'hC3, 8'h22, 0, 0, 0, 13'h0544, 1));
    vq.push_back(mk(1,0,1, 4'h9, 4'h0, 4'h9, 8'h33, 8'h00, 0, 8'h00, 8'h00, 8'h11, 0, 0, 0, 13'h0544, 1));
    vq.push_back(mk(0,0,0, 4'h9, 4'h0, 4'h0, 8'h00, 8'h00, 1, 8'h44, 8'h44, 8'h11, 0, 1, 0, 13'h0544, 1));
    vq.push_back(mk(0,0,0, 4'h9, 4'h0, 4'h0, 8'h00, 8'h00, 0, 8'h00, 8'h44, 8'h11, 0, 0, 0, 13'h0544, 1));

    for (int i = 0; i < vq.size(); i++) begin
      regEn = vq[i].re; litEn = vq[i].le; ldReq = vq[i].lq;
      SA = vq[i].sa; SB = vq[i].sb; SD = vq[i].sd;
      data = vq[i].d; lit = vq[i].l; memValid = vq[i].mv; memData = vq[i].md;
      #1;
      chk($sformatf("v%0d A", i), A, vq[i].ea);
      chk($sformatf("v%0d B", i), B, vq[i].eb);
      chk($sformatf("v%0d stall", i), stall, vq[i].est);
      chk($sformatf("v%0d pendCount", i), pendCount, vq[i].ep);
      chk($sformatf("v%0d ldFull", i), ldFull, vq[i].ef);
      chk($sformatf("v%0d pcAddData", i), pcAddData, vq[i].epc);
      chk($sformatf("v%0d memErr", i), memErr, vq[i].eerr);
      step();
    end

    // Reset asserted between edges with two loads outstanding.
    idle(); ldReq = 1; SD = 4'h1;
    step();
    SD = 4'h2;
    step();
    idle(); SA = 4'h1; SB = 4'hE;
    #1;
    chk("pre-rst pend", pendCount, 3'd2);
    chk("pre-rst A", A, 8'h0A);
    chk("pre-rst B", B, 8'h44);
    #1;
    reset = 1'b1;
    #1;
    chk("mid-rst A", A, 8'h00);
    chk("mid-rst B", B, 8'h00);
    chk("mid-rst pend", pendCount, 3'd0);
    chk("mid-rst pc", pcAddData, 13'h0000);
    chk("mid-rst memErr", memErr, 1'b0);
    chk("mid-rst ldFull", ldFull, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step();
    memValid = 1; memData = 8'h77; SA = 4'h1;
    #1;
    chk("post-rst A", A, 8'h00);
    chk("post-rst stall", stall, 1'b0);
    step();
    idle(); SA = 4'h1;
    #1;
    chk("post-rst memErr", memErr, 1'b1);
    chk("post-rst R1", A, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
